locked_mult_key_sequencer: RTL and testbench

//  Sequential front end for the 8x8 locked array multiplier (64-bit key, AOR encrypted).

---
 rtl/locked_mult_key_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_locked_mult_key_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_mult_key_sequencer.sv
// -----------------------------------------------------------------------------
// locked_mult_key_sequencer
//
// Sequential front end for the 8x8 locked array multiplier. The block shifts a
// serial unlock key into a shadow register. It commits the finished key to the
// multiplier key bus in one step. It then feeds operand pairs to the multiplier
// and registers the product the multiplier returns. Operands and results both
// use valid/ready handshakes.
//
// Parameters
//   KEY_W     unlock key width (serial bits per full load)
//   OP_W      operand width; product width is 2*OP_W
//   KEY_LOCK  1: the key can be written once until reset; 0: reload from ARMED
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   key_load_i         start or restart a serial key load
//   key_bit_i          serial key bit, MSB first, sampled when key_bit_valid_i
//   key_ready_o        committed key is on keyinput_o
//   err_o              one-cycle pulse after an illegal request
//   in_valid_i/in_ready_o, op1_i, op2_i     operand handshake
//   operand1_o, operand2_o, keyinput_o      multiplier drive
//   mult_result_i                           multiplier product (combinational)
//   out_valid_o/out_ready_i, result_o       registered product handshake
// -----------------------------------------------------------------------------
module locked_mult_key_sequencer #(
    parameter int KEY_W    = 64,
    parameter int OP_W     = 8,
    parameter bit KEY_LOCK = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              key_load_i,
    input  logic              key_bit_i,
    input  logic              key_bit_valid_i,
    output logic              key_ready_o,
    output logic              err_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [OP_W-1:0]   op1_i,
    input  logic [OP_W-1:0]   op2_i,
    output logic [OP_W-1:0]   operand1_o,
    output logic [OP_W-1:0]   operand2_o,
    output logic [KEY_W-1:0]  keyinput_o,
    input  logic [2*OP_W-1:0] mult_result_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2*OP_W-1:0] result_o
);

    typedef enum logic [2:0] {
        NOKEY,
        LOADING,
        ARMED,
        ISSUE,
        HOLD
    } state_t;

    localparam int              CNT_W    = $clog2(KEY_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d, shadow_shift;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_d;
    logic [OP_W-1:0]    op1_d, op2_d;
    logic [2*OP_W-1:0]  result_d;
    logic               key_ready_d, out_valid_d, err_d;
    logic               handshake;

    // Operands are accepted only from ARMED. This is a pure decode of the
    // state register, so it carries no combinational path from any input.
    assign in_ready_o   = (state_q == ARMED);
    assign handshake    = in_valid_i & in_ready_o;
    assign shadow_shift = {shadow_q[KEY_W-2:0], key_bit_i};

    // NOTE: every signal gets its hold value before the case statement. A
    // branch that forgets an assignment then keeps the register value and
    // does not infer a latch.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        key_d       = keyinput_o;
        op1_d       = operand1_o;
        op2_d       = operand2_o;
        result_d    = result_o;
        key_ready_d = key_ready_o;
        out_valid_d = out_valid_o;
        err_d       = 1'b0;

        case (state_q)
            NOKEY: begin
                if (in_valid_i) begin
                    err_d = 1'b1;
                end
                if (key_load_i) begin
                    state_d  = LOADING;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end

            LOADING: begin
                key_ready_d = 1'b0;
                // A restart takes priority over a key bit in the same cycle,
                // so the new key never carries a stale first bit.
                if (key_load_i) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (key_bit_valid_i) begin
                    shadow_d = shadow_shift;
                    if (cnt_q == LAST_BIT) begin
                        // The key bus changes only here, in one step. It
                        // keeps the old key for the whole load.
                        key_d       = shadow_shift;
                        key_ready_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ARMED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ARMED: begin
                if (handshake) begin
                    op1_d   = op1_i;
                    op2_d   = op2_i;
                    state_d = ISSUE;
                    // If a key load arrives with an operand, the operand wins.
                    // The load is dropped and flagged.
                    if (key_load_i) begin
                        err_d = 1'b1;
                    end
                end else if (key_load_i) begin
                    if (KEY_LOCK) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = LOADING;
                        cnt_d       = '0;
                        shadow_d    = '0;
                        key_ready_d = 1'b0;
                    end
                end
            end

            ISSUE: begin
                // One cycle lets the multiplier settle on the new operands.
                result_d    = mult_result_i;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end

            HOLD: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ARMED;
                end
            end

            default: begin
                state_d = NOKEY;
            end
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments. Every
    // register then samples its pre-edge value, whatever order the
    // statements are in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= NOKEY;
            // NOTE: the shadow key register is cleared on reset like every
            // other register. Partial key material must not survive a reset.
            shadow_q    <= '0;
            cnt_q       <= '0;
            keyinput_o  <= '0;
            operand1_o  <= '0;
            operand2_o  <= '0;
            result_o    <= '0;
            key_ready_o <= 1'b0;
            out_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            keyinput_o  <= key_d;
            operand1_o  <= op1_d;
            operand2_o  <= op2_d;
            result_o    <= result_d;
            key_ready_o <= key_ready_d;
            out_valid_o <= out_valid_d;
            err_o       <= err_d;
        end
    end

endmodule

// File: tb/tb_locked_mult_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_locked_mult_key_sequencer
//
// Two instances share clock, reset and most stimulus:
//   u_lock  KEY_LOCK=1   (driven by key_load_a)
//   u_free  KEY_LOCK=0   (driven by key_load_b)
// The multiplier stand-in is a plain behavioural product of each instance's
// own operand outputs. Expected keys are rebuilt from the bits the bench
// shifts. Expected products are computed from the operands the bench sends.
// -----------------------------------------------------------------------------
module tb_locked_mult_key_sequencer;

    localparam logic [63:0] K1 = 64'h4B72AAC6D650642F;
    localparam logic [63:0] K2 = 64'h4B72AAC6D650640F;

    logic        clk, rst;
    logic        key_load_a, key_load_b, key_bit, key_bit_valid;
    logic        in_valid, out_ready;
    logic [7:0]  op1, op2;

    logic        key_ready_a, err_a, in_ready_a, out_valid_a;
    logic [7:0]  opnd1_a, opnd2_a;
    logic [63:0] keyin_a;
    logic [15:0] mult_a, res_a;

    logic        key_ready_b, err_b, in_ready_b, out_valid_b;
    logic [7:0]  opnd1_b, opnd2_b;
    logic [63:0] keyin_b;
    logic [15:0] mult_b, res_b;

    assign mult_a = 16'(opnd1_a) * 16'(opnd2_a);
    assign mult_b = 16'(opnd1_b) * 16'(opnd2_b);

    locked_mult_key_sequencer #(.KEY_W(64), .OP_W(8), .KEY_LOCK(1'b1)) u_lock (
        .clk_i(clk), .rst_i(rst), .key_load_i(key_load_a), .key_bit_i(key_bit),
        .key_bit_valid_i(key_bit_valid), .key_ready_o(key_ready_a), .err_o(err_a),
        .in_valid_i(in_valid), .in_ready_o(in_ready_a), .op1_i(op1), .op2_i(op2),
        .operand1_o(opnd1_a), .operand2_o(opnd2_a), .keyinput_o(keyin_a),
        .mult_result_i(mult_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
        .result_o(res_a)
    );

    locked_mult_key_sequencer #(.KEY_W(64), .OP_W(8), .KEY_LOCK(1'b0)) u_free (
        .clk_i(clk), .rst_i(rst), .key_load_i(key_load_b), .key_bit_i(key_bit),
        .key_bit_valid_i(key_bit_valid), .key_ready_o(key_ready_b), .err_o(err_b),
        .in_valid_i(in_valid), .in_ready_o(in_ready_b), .op1_i(op1), .op2_i(op2),
        .operand1_o(opnd1_b), .operand2_o(opnd2_b), .keyinput_o(keyin_b),
        .mult_result_i(mult_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
        .result_o(res_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [63:0] exp_key_a, exp_key_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, {key_ready_a, err_a, in_ready_a, out_valid_a, res_a, opnd1_a, opnd2_a}, 64'd0);
        check({tag, "_b"}, {key_ready_b, err_b, in_ready_b, out_valid_b, res_b, opnd1_b, opnd2_b}, 64'd0);
        check({tag, "_key_a"}, keyin_a, 64'd0);
        check({tag, "_key_b"}, keyin_b, 64'd0);
    endtask

    // Shift the top n bits of k, MSB first, with random valid gaps. la/lb
    // mark which instance is loading. A non-loading instance must stay
    // ARMED with its key untouched.
    task automatic shift_bits(input logic [63:0] k, input int n, input bit la, input bit lb);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                key_bit_valid = 1'b0;
                key_bit       = 1'($urandom);
                tick();
            end
            key_bit_valid = 1'b1;
            key_bit       = k[63-i];
            acc           = {acc[62:0], key_bit};
            tick();
            key_bit_valid = 1'b0;
            if (i == 63) begin
                if (la) exp_key_a = acc;
                if (lb) exp_key_b = acc;
            end
            check("key_a", keyin_a, exp_key_a);
            check("key_b", keyin_b, exp_key_b);
            check("key_ready_a", 64'(key_ready_a), la ? 64'(i == 63) : 64'd1);
            check("key_ready_b", 64'(key_ready_b), lb ? 64'(i == 63) : 64'd1);
        end
    endtask

    task automatic pulse_load_both();
        key_load_a = 1'b1;
        key_load_b = 1'b1;
        tick();
        key_load_a = 1'b0;
        key_load_b = 1'b0;
        check("load_err", {err_a, err_b, key_ready_a, key_ready_b}, 64'd0);
    endtask

    // Full operand/result transaction on both instances. Setting load_b
    // raises key_load_b on the handshake cycle. Setting hold keeps
    // out_ready low for that many cycles while noise is driven.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int hold, input bit load_b);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        check("pre_in_ready", {in_ready_a, in_ready_b}, 64'b11);
        in_valid   = 1'b1;
        op1        = a;
        op2        = b;
        key_load_b = load_b;
        tick();                                   // handshake edge
        in_valid   = 1'b0;
        key_load_b = 1'b0;
        op1        = 8'($urandom);
        op2        = 8'($urandom);
        check("opnd_a", {opnd1_a, opnd2_a}, {a, b});
        check("opnd_b", {opnd1_b, opnd2_b}, {a, b});
        check("early_valid", {out_valid_a, out_valid_b, in_ready_a, in_ready_b}, 64'd0);
        check("hs_err", {err_a, err_b}, {1'b0, load_b});
        tick();                                   // settle edge: product registered
        check("valid", {out_valid_a, out_valid_b}, 64'b11);
        check("result_a", res_a, prod);
        check("result_b", res_b, prod);
        check("issue_err", {err_a, err_b}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid   = 1'b1;
            key_load_a = 1'b1;
            key_load_b = 1'b1;
            tick();
            check("hold_valid", {out_valid_a, out_valid_b}, 64'b11);
            check("hold_result", {res_a, res_b}, {prod, prod});
            check("hold_ready_err", {in_ready_a, in_ready_b, err_a, err_b}, 64'd0);
        end
        in_valid   = 1'b0;
        key_load_a = 1'b0;
        key_load_b = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready  = 1'b0;
        check("drain", {out_valid_a, out_valid_b, in_ready_a, in_ready_b}, 64'b0011);
        check("opnd_persist", {opnd1_a, opnd2_a, opnd1_b, opnd2_b}, {a, b, a, b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        key_load_a = 1'b0; key_load_b = 1'b0; key_bit = 1'b0; key_bit_valid = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0;
        exp_key_a = '0; exp_key_b = '0;

        // Reset state
        tick(); tick();
        check_all_zero("reset");
        #3 rst = 1'b0;

        // T3: operands before any key are refused with one error pulse
        tick();
        in_valid = 1'b1; op1 = 8'h5C; op2 = 8'hA3;
        check("nokey_in_ready", {in_ready_a, in_ready_b}, 64'd0);
        tick();
        in_valid = 1'b0;
        check("nokey_err", {err_a, err_b}, 64'b11);
        check("nokey_nocapture", {opnd1_a, opnd2_a, opnd1_b, opnd2_b}, 64'd0);
        tick();
        check("nokey_err_pulse", {err_a, err_b}, 64'd0);

        // T1: serial key load with random gaps
        pulse_load_both();
        shift_bits(K1, 64, 1'b1, 1'b1);
        check("t1_key", keyin_a, K1);

        // T2: directed pairs, then random pairs
        send_pair(8'h29, 8'h7A, 0, 1'b0);
        send_pair(8'h44, 8'h3B, 1, 1'b0);
        send_pair(8'h89, 8'hFF, 5, 1'b0);
        send_pair(8'h80, 8'h80, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            send_pair(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        // T4: a locked instance refuses a reload
        key_load_a = 1'b1;
        tick();
        key_load_a = 1'b0;
        check("lock_err", {err_a, err_b}, 64'b10);
        check("lock_key", keyin_a, K1);
        check("lock_armed", {key_ready_a, in_ready_a}, 64'b11);
        tick();
        check("lock_err_pulse", 64'(err_a), 64'd0);

        // T4: an unlocked instance reloads; the old key holds until the 64th bit
        key_load_b = 1'b1;
        tick();
        key_load_b = 1'b0;
        check("reload_start", {err_b, key_ready_b, in_ready_b}, 64'd0);
        check("reload_old_key", keyin_b, K1);
        shift_bits(K2, 64, 1'b0, 1'b1);
        check("reload_key", keyin_b, K2);
        // A key load together with a handshake: the operand wins and the load is flagged
        send_pair(8'h3C, 8'hC3, 0, 1'b1);
        check("drop_load_key", {key_ready_b, 63'd0}, {1'b1, 63'd0});
        check("drop_load_keyval", keyin_b, K2);

        // T6: async reset mid-cycle while in HOLD
        in_valid = 1'b1; op1 = 8'h77; op2 = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_valid", {out_valid_a, out_valid_b}, 64'b11);
        #3 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_key_a = '0;
        exp_key_b = '0;
        tick(); tick();
        #3 rst = 1'b0;
        tick();
        in_valid = 1'b1; op1 = 8'h12; op2 = 8'h34;
        tick();
        in_valid = 1'b0;
        check("post_rst_refuse", {err_a, err_b, in_ready_a, in_ready_b}, 64'b1100);
        check("post_rst_nocapture", {opnd1_a, opnd2_a}, 64'd0);
        tick();

        // T5: restart after 30 bits; a key bit in the restart cycle is dropped
        pulse_load_both();
        shift_bits(64'($urandom) << 32 | 64'($urandom), 30, 1'b1, 1'b1);
        key_load_a = 1'b1; key_load_b = 1'b1;
        key_bit_valid = 1'b1; key_bit = 1'b1;
        tick();
        key_load_a = 1'b0; key_load_b = 1'b0; key_bit_valid = 1'b0;
        check("restart_not_ready", {key_ready_a, key_ready_b, err_a, err_b}, 64'd0);
        shift_bits(K1, 64, 1'b1, 1'b1);
        check("restart_key_a", keyin_a, K1);
        check("restart_key_b", keyin_b, K1);
        send_pair(8'hFF, 8'hFF, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
